// File: rtl/bram_rd_port.sv
`default_nettype none
// ============================================================================
//  Module   : bram_rd_port
//  Purpose  : Read-side front end for the cache's simple dual-port BRAM.
//             Registered, back-pressurable read responses. When
//             BRAM_RD_FWD_EN is defined, port-A byte writes are merged
//             into reads that are still in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module bram_rd_port #(
    parameter int LEN_DATA  = 32,
    parameter int LEN_ADDR  = 8,
    parameter int byteWidth = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [LEN_ADDR-1:0]           req_addr,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [LEN_DATA-1:0]           resp_data,
    input  logic                          wr_en,
    input  logic [LEN_DATA/byteWidth-1:0] wr_we,
    input  logic [LEN_ADDR-1:0]           wr_addr,
    input  logic [LEN_DATA-1:0]           wr_data,
    output logic                          bram_ena,
    output logic [LEN_DATA/byteWidth-1:0] bram_wea,
    output logic [LEN_ADDR-1:0]           bram_addra,
    output logic [LEN_DATA-1:0]           bram_dina,
    output logic                          bram_enb,
    output logic [LEN_ADDR-1:0]           bram_addrb,
    input  logic [LEN_DATA-1:0]           bram_doutb
);

    localparam int NB = LEN_DATA / byteWidth;

    logic                p_valid_q, p_valid_d;
    logic                o_valid_q, o_valid_d;
    logic [LEN_DATA-1:0] o_data_q,  o_data_d;
    logic                p_move;
    logic                accept;

`ifdef BRAM_RD_FWD_EN
    logic [LEN_ADDR-1:0] p_addr_q, p_addr_d;
    logic [LEN_ADDR-1:0] o_addr_q, o_addr_d;
    logic [NB-1:0]       p_mask_q, p_mask_d;
    logic [LEN_DATA-1:0] p_fwd_q,  p_fwd_d;
    logic                wr_hit_req, wr_hit_p, wr_hit_o;

    assign wr_hit_req = wr_en && (wr_addr == req_addr);
    assign wr_hit_p   = wr_en && (wr_addr == p_addr_q);
    assign wr_hit_o   = wr_en && (wr_addr == o_addr_q);
`endif

    // Port A traffic is only observed here, never gated.
    assign bram_ena   = wr_en;
    assign bram_wea   = wr_we;
    assign bram_addra = wr_addr;
    assign bram_dina  = wr_data;

    assign p_move     = p_valid_q && (!o_valid_q || resp_ready);
    assign req_ready  = !p_valid_q || p_move;
    assign accept     = req_valid && req_ready;
    assign bram_enb   = accept;
    assign bram_addrb = req_addr;
    assign resp_valid = o_valid_q;
    assign resp_data  = o_data_q;

    // Stage P: read in flight, doutb for it is held by the array.
    always_comb begin
        p_valid_d = p_valid_q;
        if (accept)
            p_valid_d = 1'b1;
        else if (p_move)
            p_valid_d = 1'b0;
`ifdef BRAM_RD_FWD_EN
        p_addr_d = p_addr_q;
        p_mask_d = p_mask_q;
        p_fwd_d  = p_fwd_q;
        if (accept) begin
            // Same-edge collision: the array returns pre-write data.
            p_addr_d = req_addr;
            p_mask_d = '0;
            p_fwd_d  = '0;
            if (wr_hit_req) begin
                p_mask_d = wr_we;
                for (int b = 0; b < NB; b++)
                    if (wr_we[b])
                        p_fwd_d[b*byteWidth +: byteWidth] = wr_data[b*byteWidth +: byteWidth];
            end
        end else if (p_move) begin
            p_mask_d = '0;
            p_fwd_d  = '0;
        end else if (p_valid_q && wr_hit_p) begin
            p_mask_d = p_mask_q | wr_we;
            for (int b = 0; b < NB; b++)
                if (wr_we[b])
                    p_fwd_d[b*byteWidth +: byteWidth] = wr_data[b*byteWidth +: byteWidth];
        end
`endif
    end

    // Stage O: output register.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
`ifdef BRAM_RD_FWD_EN
        o_addr_d  = o_addr_q;
`endif
        if (p_move) begin
            o_valid_d = 1'b1;
`ifdef BRAM_RD_FWD_EN
            o_addr_d  = p_addr_q;
            // Priority: write this cycle, then captured writes, then array.
            for (int b = 0; b < NB; b++) begin
                if (wr_hit_p && wr_we[b])
                    o_data_d[b*byteWidth +: byteWidth] = wr_data[b*byteWidth +: byteWidth];
                else if (p_mask_q[b])
                    o_data_d[b*byteWidth +: byteWidth] = p_fwd_q[b*byteWidth +: byteWidth];
                else
                    o_data_d[b*byteWidth +: byteWidth] = bram_doutb[b*byteWidth +: byteWidth];
            end
`else
            o_data_d  = bram_doutb;
`endif
        end else if (resp_ready) begin
            o_valid_d = 1'b0;
        end
`ifdef BRAM_RD_FWD_EN
        else if (o_valid_q && wr_hit_o) begin
            for (int b = 0; b < NB; b++)
                if (wr_we[b])
                    o_data_d[b*byteWidth +: byteWidth] = wr_data[b*byteWidth +: byteWidth];
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_valid_q <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
`ifdef BRAM_RD_FWD_EN
            p_addr_q  <= '0;
            o_addr_q  <= '0;
            p_mask_q  <= '0;
            p_fwd_q   <= '0;
`endif
        end else begin
            p_valid_q <= p_valid_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
`ifdef BRAM_RD_FWD_EN
            p_addr_q  <= p_addr_d;
            o_addr_q  <= o_addr_d;
            p_mask_q  <= p_mask_d;
            p_fwd_q   <= p_fwd_d;
`endif
        end
    end

endmodule
`default_nettype wire
